// File: rtl/sensor_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_cond_pkg
// Brief    : Shared types and constants for the sensor conditioning front end.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_cond_pkg;

    // Per-channel debounce FSM encoding
    typedef enum logic [0:0] {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

    // Increment that sticks at GLITCH_MAX instead of wrapping
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + GLITCH_W'(1);
    endfunction

endpackage : sensor_cond_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Brief    : One sensor channel: synchroniser chain, debounce FSM with hold
//            counter, saturating glitch counter and registered rise pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce
    import sensor_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sensor,
    output logic                o_clean,
    output logic                o_clean_nxt,
    output logic                o_rise,
    output logic [GLITCH_W-1:0] o_glitch_cnt
);

    localparam logic [CNT_W-1:0] c_db_target = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_sync;
    db_state_t              r_state;
    db_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_clean;
    logic                   w_clean_nxt;
    logic                   w_glitch;
    logic                   r_rise;
    logic [GLITCH_W-1:0]    r_glitch_cnt;

    assign w_s_sync = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain; bit 0 is the first stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sensor};
        end
    end

    // Debounce decision: a new level must persist through the full hold count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_glitch    = 1'b0;
        case (r_state)
            DB_STABLE: begin
                w_cnt_nxt = '0;
                if (w_s_sync != r_clean) begin
                    w_state_nxt = DB_PENDING;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            DB_PENDING: begin
                if (w_s_sync == r_clean) begin
                    // Level fell back before the hold completed: reject it
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == c_db_target) begin
                    w_clean_nxt = ~r_clean;
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = DB_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register FSM state, hold counter, clean level, rise pulse and glitch count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DB_STABLE;
            r_cnt        <= '0;
            r_clean      <= 1'b0;
            r_rise       <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_clean_nxt & ~r_clean;
            if (w_glitch) begin
                r_glitch_cnt <= sat_inc(r_glitch_cnt);
            end
        end
    end

    assign o_clean      = r_clean;
    // Next clean level lets the parent register combined edges in step
    assign o_clean_nxt  = rst ? 1'b0 : w_clean_nxt;
    assign o_rise       = r_rise;
    assign o_glitch_cnt = r_glitch_cnt;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_conditioner
// Brief    : Two-channel sensor front end: synchronise and debounce each pin,
//            and flag when both clean levels become active together.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sensor1,
    input  logic                sensor2,
    output logic                sensor1_clean,
    output logic                sensor2_clean,
    output logic                sensor1_rise,
    output logic                sensor2_rise,
    output logic                both_active,
    output logic                both_rise,
    output logic [GLITCH_W-1:0] glitch1_cnt,
    output logic [GLITCH_W-1:0] glitch2_cnt
);

    logic w_clean1_nxt;
    logic w_clean2_nxt;
    logic r_both_rise;

    sensor_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db1 (
        .clk         (clk),
        .rst         (rst),
        .i_sensor    (sensor1),
        .o_clean     (sensor1_clean),
        .o_clean_nxt (w_clean1_nxt),
        .o_rise      (sensor1_rise),
        .o_glitch_cnt(glitch1_cnt)
    );

    sensor_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db2 (
        .clk         (clk),
        .rst         (rst),
        .i_sensor    (sensor2),
        .o_clean     (sensor2_clean),
        .o_clean_nxt (w_clean2_nxt),
        .o_rise      (sensor2_rise),
        .o_glitch_cnt(glitch2_cnt)
    );

    assign both_active = sensor1_clean & sensor2_clean;

    // Pulse on the first cycle both clean levels are high, aligned with the channel pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_both_rise <= 1'b0;
        end else begin
            r_both_rise <= w_clean1_nxt & w_clean2_nxt & ~both_active;
        end
    end

    assign both_rise = r_both_rise;

endmodule : sensor_conditioner
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_conditioner
// Brief    : Scoreboard bench for sensor_conditioner with a run-length
//            reference model, directed scenarios and randomized pin activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor1 = 1'b0;
    logic       sensor2 = 1'b0;
    logic       sensor1_clean, sensor2_clean, sensor1_rise, sensor2_rise;
    logic       both_active, both_rise;
    logic [7:0] glitch1_cnt, glitch2_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    sensor_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .sensor1_clean(sensor1_clean),
        .sensor2_clean(sensor2_clean),
        .sensor1_rise (sensor1_rise),
        .sensor2_rise (sensor2_rise),
        .both_active  (both_active),
        .both_rise    (both_rise),
        .glitch1_cnt  (glitch1_cnt),
        .glitch2_cnt  (glitch2_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A channel's clean level flips once the synchronised input has disagreed
    // with it for DEB+1 consecutive samples; a shorter disagreement is a glitch.
    bit sq0[$];
    bit sq1[$];
    int m_run[2];
    bit m_clean[2];
    int m_glitch[2];
    bit m_rise[2];
    bit m_both_rise;

    logic [21:0] sb[$];

    task automatic model_reset();
        sq0.delete();
        sq1.delete();
        for (int i = 0; i < SYNC; i++) begin
            sq0.push_back(1'b0);
            sq1.push_back(1'b0);
        end
        for (int c = 0; c < 2; c++) begin
            m_run[c] = 0; m_clean[c] = 0; m_glitch[c] = 0; m_rise[c] = 0;
        end
        m_both_rise = 0;
    endtask

    task automatic model_step(input bit r, input bit a, input bit b, output logic [21:0] e);
        bit ss[2];
        bit prev_both;
        if (r) begin
            model_reset();
        end else begin
            prev_both = m_clean[0] & m_clean[1];
            ss[0] = sq0.pop_front(); sq0.push_back(a);
            ss[1] = sq1.pop_front(); sq1.push_back(b);
            for (int c = 0; c < 2; c++) begin
                m_rise[c] = 0;
                if (ss[c] != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] > DEB) begin
                        m_clean[c] = ~m_clean[c];
                        m_rise[c]  = m_clean[c];
                        m_run[c]   = 0;
                    end
                end else begin
                    if (m_run[c] > 0 && m_glitch[c] < 255) m_glitch[c]++;
                    m_run[c] = 0;
                end
            end
            m_both_rise = (m_clean[0] & m_clean[1]) & ~prev_both;
        end
        e = {m_clean[0], m_clean[1], m_rise[0], m_rise[1], m_clean[0] & m_clean[1],
             m_both_rise, 8'(m_glitch[0]), 8'(m_glitch[1])};
    endtask

    function automatic logic [21:0] dut_vec();
        return {sensor1_clean, sensor2_clean, sensor1_rise, sensor2_rise,
                both_active, both_rise, glitch1_cnt, glitch2_cnt};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [21:0] e;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (dut_vec() !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle %0d: got %h expected %h", n_cycle, dut_vec(), e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the predicted outputs, return after the edge
    task automatic step(input bit r, input bit a, input bit b);
        logic [21:0] e;
        @(negedge clk);
        rst = r; sensor1 = a; sensor2 = b;
        model_step(r, a, b, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    bit saw_rise;
    bit lv[2];
    int rl[2];

    initial begin
        model_reset();

        // T1: reset with sensors high, then release and time the acceptance
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("T1 outputs in reset", {10'd0, dut_vec()}, 32'd0);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("T1 sensor1_clean latency", sensor1_clean, i >= 11);
            chk("T1 sensor1_rise pulse", sensor1_rise, i == 11);
        end

        // T2: 5-cycle glitch is rejected
        do_reset();
        for (int i = 0; i < 25; i++) begin
            step(1'b0, i < 5, 1'b0);
            chk("T2 clean stays low", sensor1_clean, 1'b0);
            chk("T2 no rise", sensor1_rise, 1'b0);
        end
        chk("T2 glitch1_cnt", glitch1_cnt, 8'd1);

        // T3: hold-length boundary
        do_reset();
        for (int i = 0; i < 27; i++) step(1'b0, i < 7, 1'b0);
        chk("T3 len7 glitch", glitch1_cnt, 8'd1);
        for (int i = 0; i < 28; i++) step(1'b0, i < DEB, 1'b0);
        chk("T3 len8 glitch", glitch1_cnt, 8'd2);
        chk("T3 len8 clean", sensor1_clean, 1'b0);
        saw_rise = 0;
        for (int i = 0; i < 29; i++) begin
            step(1'b0, i < DEB + 1, 1'b0);
            if (sensor1_rise) saw_rise = 1;
        end
        chk("T3 len9 accepted", saw_rise, 1'b1);
        chk("T3 len9 no glitch", glitch1_cnt, 8'd2);

        // T4: simultaneous rise
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("T4 both_rise", both_rise, i == 11);
            chk("T4 sensor1_rise", sensor1_rise, i == 11);
            chk("T4 sensor2_rise", sensor2_rise, i == 11);
        end
        chk("T4 both_active held", both_active, 1'b1);

        // T5: staggered rise, then sensor1 drops
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("T5 both_rise", both_rise, j == 11);
            chk("T5 sensor2_rise", sensor2_rise, j == 11);
            chk("T5 sensor1_rise quiet", sensor1_rise, 1'b0);
        end
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("T5 both_active fall", both_active, k <= 10);
            chk("T5 no both_rise", both_rise, 1'b0);
        end

        // T6: glitch saturation, then reset mid-pending
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("T6 glitch2 saturated", glitch2_cnt, 8'd255);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("T6 glitch2 cleared", glitch2_cnt, 8'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("T6 no rise after reset", sensor1_rise, 1'b0);
            chk("T6 clean low", sensor1_clean, 1'b0);
        end
        chk("T6 glitch1 after reset", glitch1_cnt, 8'd0);

        // Randomized runs of varying length on both pins, with occasional resets
        do_reset();
        lv[0] = 0; lv[1] = 0; rl[0] = 0; rl[1] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rl[c] == 0) begin
                    lv[c] = ~lv[c];
                    rl[c] = $urandom_range(1, 14);
                end
                rl[c]--;
            end
            step($urandom_range(0, 599) == 0, lv[0], lv[1]);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sensor_conditioner
`default_nettype wire
